// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer with valid/ready input handshake.
// Emits one bit per clock with a valid strobe and a last-bit marker.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             d_out,
    output logic             d_out_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             at_last;
    logic             in_shift;
    logic             accept;
    logic             head_bit;

    // Shift direction and output tap depend only on bit order.
    always_comb begin
        if (LSB_FIRST) begin
            shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
            head_bit      = shreg[0];
        end else begin
            shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
            head_bit      = shreg[WIDTH-1];
        end
    end

    // Handshake and next-state logic; ready depends on registered state only.
    always_comb begin
        in_shift   = (state == SHIFT);
        at_last    = (cnt == CNT_LAST);
        din_ready  = !in_shift || at_last;
        accept     = din_valid && din_ready;
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        if (accept) begin
            state_next = SHIFT;
            shreg_next = din;
            cnt_next   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                SHIFT: begin
                    if (at_last) begin
                        state_next = IDLE;
                    end else begin
                        shreg_next = shreg_shifted;
                        cnt_next   = cnt + CW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Serial outputs are gated by state so IDLE always presents zeros.
    always_comb begin
        d_out_valid = in_shift;
        busy        = in_shift;
        last        = in_shift && at_last;
        d_out       = in_shift && head_bit;
    end

    // State register; reset clears everything without waiting for clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (MSB-first and LSB-first).
// Stimulus pushes expected bits; a negedge monitor pops and compares.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] din = 4'b0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       d_out;
    logic       d_out_valid;
    logic       last;
    logic       busy;

    logic [3:0] din_l = 4'b0;
    logic       din_valid_l = 1'b0;
    logic       din_ready_l;
    logic       d_out_l;
    logic       d_out_valid_l;
    logic       last_l;
    logic       busy_l;

    logic [3:0] sipo_q;

    int vectors = 0;
    int miscompares = 0;
    int run = 0;
    int max_run = 0;

    logic [1:0] exp_q[$];
    logic [1:0] exp_l[$];

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .d_out(d_out),
        .d_out_valid(d_out_valid),
        .last(last),
        .busy(busy)
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk),
        .reset(reset),
        .din(din_l),
        .din_valid(din_valid_l),
        .din_ready(din_ready_l),
        .d_out(d_out_l),
        .d_out_valid(d_out_valid_l),
        .last(last_l),
        .busy(busy_l)
    );

    always #5 clk = ~clk;

    // Loopback receiver: 4-bit SIPO fed from the MSB-first serial output.
    always @(posedge clk or negedge reset) begin
        if (!reset) sipo_q <= 4'b0;
        else        sipo_q <= {sipo_q[2:0], d_out};
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Push the first n bits of a serial pattern, read MSB to LSB.
    task automatic push(input bit lsb, input logic [3:0] pat, input int n);
        logic [1:0] e;
        for (int i = 0; i < n; i++) begin
            e = {pat[3-i], (i == 3) ? 1'b1 : 1'b0};
            if (lsb) exp_l.push_back(e);
            else     exp_q.push_back(e);
        end
    endtask

    // Present a word to the MSB-first DUT; returns edges waited before accept.
    task automatic present(input logic [3:0] w, input int n, output int waited);
        din = w;
        din_valid = 1'b1;
        waited = 0;
        while (din_ready !== 1'b1 && waited <= 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (din_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got ready=%b expected 1", din_ready);
            din_valid = 1'b0;
        end else begin
            @(posedge clk);
            push(1'b0, w, n);
            #1;
        end
    endtask

    // Monitor: compare every valid bit against the scoreboard queues.
    always @(negedge clk) begin
        logic [1:0] e;
        check("busy_eq_valid", {31'b0, busy}, {31'b0, d_out_valid});
        if (d_out_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL msb_bit: got bit=%b last=%b expected none",
                         d_out, last);
            end else begin
                e = exp_q.pop_front();
                check("msb_bit_last", {30'b0, d_out, last}, {30'b0, e});
            end
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (d_out_valid_l) begin
            if (exp_l.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL lsb_bit: got bit=%b last=%b expected none",
                         d_out_l, last_l);
            end else begin
                e = exp_l.pop_front();
                check("lsb_bit_last", {30'b0, d_out_l, last_l}, {30'b0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int k;
        logic [3:0] lb[3];
        lb[0] = 4'b1011;
        lb[1] = 4'b0110;
        lb[2] = 4'b1001;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, din_ready}, 32'd1);
        check("rst_valid", {31'b0, d_out_valid}, 32'd0);
        check("rst_dout", {31'b0, d_out}, 32'd0);
        check("rst_last", {31'b0, last}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single word, then one idle cycle.
        max_run = 0;
        present(4'b1011, 4, w);
        din_valid = 1'b0;
        check("single_wait", 32'(w), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("idle_valid", {31'b0, d_out_valid}, 32'd0);
        check("idle_dout", {31'b0, d_out}, 32'd0);
        check("idle_ready", {31'b0, din_ready}, 32'd1);
        check("idle_last", {31'b0, last}, 32'd0);
        check("single_run", 32'(max_run), 32'd4);
        @(posedge clk);
        #1;

        // Back-to-back words with din_valid held high.
        max_run = 0;
        present(4'b1011, 4, w);
        present(4'b0110, 4, w);
        din_valid = 1'b0;
        check("b2b_wait", 32'(w), 32'd3);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_run", 32'(max_run), 32'd8);

        // Stall: new word offered in cycle 2 of a word in flight.
        present(4'b1011, 4, w);
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        din = 4'b0001;
        din_valid = 1'b1;
        check("stall_ready", {31'b0, din_ready}, 32'd0);
        present(4'b0001, 4, w);
        din_valid = 1'b0;
        check("stall_wait", 32'(w), 32'd2);
        repeat (5) @(posedge clk);
        #1;

        // Reset pulse during bit 2 of 4'b1111.
        present(4'b1111, 2, w);
        din_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("arst_valid", {31'b0, d_out_valid}, 32'd0);
        check("arst_dout", {31'b0, d_out}, 32'd0);
        check("arst_last", {31'b0, last}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_ready", {31'b0, din_ready}, 32'd1);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        present(4'b0101, 4, w);
        din_valid = 1'b0;
        check("post_rst_wait", 32'(w), 32'd0);
        repeat (5) @(posedge clk);
        #1;

        // Loopback into the SIPO receiver.
        for (int i = 0; i < 3; i++) begin
            present(lb[i], 4, w);
            din_valid = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("loopback_q", {28'b0, sipo_q}, {28'b0, lb[i]});
            @(posedge clk);
            #1;
        end

        // LSB-first instance: 4'b1011 goes out as 1,1,0,1.
        din_l = 4'b1011;
        din_valid_l = 1'b1;
        check("lsb_ready", {31'b0, din_ready_l}, 32'd1);
        @(posedge clk);
        push(1'b1, 4'b1101, 4);
        #1;
        din_valid_l = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        k = 0;
        while ((exp_q.size() != 0 || exp_l.size() != 0) && k < 50) begin
            @(posedge clk);
            k++;
        end
        check("drain", 32'(exp_q.size() + exp_l.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
